// File: rtl/rastreador_posicao.sv
// rastreador_posicao: drone position tracker and move-event generator.
// Synchronizes and debounces the four direction buttons, turns each debounced
// press into at most one move on an 8x8 grid while the control unit accepts
// moves, and reports collision / end-of-map levels for the committed move.
// Optional build macro RASTREADOR_WRAP_X_EN: horizontal moves wrap x 0<->7
// instead of hitting the side walls.
module rastreador_posicao #(
    parameter int unsigned  DEBOUNCE_CICLOS = 16,
    parameter logic [63:0]  MAPA            = 64'h0000_0000_0010_0000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       zeraPosicoes,
    input  logic       desloca,
    input  logic       checa_colisao,
    input  logic [3:0] botoes,
    output logic       borda_movimento,
    output logic       colisao,
    output logic       fim_mapa,
    output logic [2:0] pos_x,
    output logic [2:0] pos_y,
    output logic [1:0] db_estado
);

    // Counter reaches this value on the last differing sample before the flip.
    localparam logic [7:0] LIMITE = 8'(DEBOUNCE_CICLOS - 32'd1);

    // Start cell (3,0); its map bit is never treated as an obstacle.
    localparam logic [2:0] X_INICIAL      = 3'd3;
    localparam logic [2:0] Y_INICIAL      = 3'd0;
    localparam logic [5:0] INDICE_INICIAL = 6'd3;

    typedef enum logic [1:0] {
        LIVRE    = 2'd0,
        BLOQUEIO = 2'd1
    } estado_t;

    typedef enum logic [1:0] {
        DIR_CIMA     = 2'd0,
        DIR_BAIXO    = 2'd1,
        DIR_ESQUERDA = 2'd2,
        DIR_DIREITA  = 2'd3
    } direcao_t;

    logic [3:0]      r_sinc1;
    logic [3:0]      r_sinc2;
    logic [3:0]      r_nivel;
    logic [3:0]      r_nivel_ant;
    logic [3:0][7:0] r_cont;

    estado_t         r_estado;
    estado_t         w_prox_estado;
    logic            w_commit;

    logic [2:0]      r_pos_x;
    logic [2:0]      r_pos_y;
    logic            r_colisao;
    logic            r_fim_mapa;
    logic            r_borda;

    logic [3:0]      w_evento;
    logic            w_tem_evento;
    direcao_t        w_direcao;
    logic [2:0]      w_alvo_x;
    logic [2:0]      w_alvo_y;
    logic            w_fora;
    logic [5:0]      w_indice;
    logic            w_obstaculo;

    // Two-flop synchronizer for the raw button inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sinc1 <= 4'd0;
            r_sinc2 <= 4'd0;
        end else begin
            r_sinc1 <= botoes;
            r_sinc2 <= r_sinc1;
        end
    end

    // Per-button debounce: flip the level after LIMITE+1 consecutive differing samples.
    // Restart does not touch these so a held button cannot fire again.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_nivel <= 4'd0;
            r_cont  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sinc2[i] != r_nivel[i]) begin
                    if (r_cont[i] == LIMITE) begin
                        r_nivel[i] <= r_sinc2[i];
                        r_cont[i]  <= 8'd0;
                    end else begin
                        r_cont[i]  <= r_cont[i] + 8'd1;
                    end
                end else begin
                    r_cont[i] <= 8'd0;
                end
            end
        end
    end

    // Previous debounced level for rising-edge detection; restart realigns it
    // so no pending edge survives.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_nivel_ant <= 4'd0;
        end else if (zeraPosicoes) begin
            r_nivel_ant <= r_nivel;
        end else begin
            r_nivel_ant <= r_nivel;
        end
    end

    assign w_evento     = r_nivel & ~r_nivel_ant;
    assign w_tem_evento = |w_evento;

    // Pick a single direction when several presses land together: cima > baixo > esquerda > direita.
    always_comb begin
        w_direcao = DIR_DIREITA;
        if (w_evento[3]) begin
            w_direcao = DIR_CIMA;
        end else if (w_evento[2]) begin
            w_direcao = DIR_BAIXO;
        end else if (w_evento[1]) begin
            w_direcao = DIR_ESQUERDA;
        end else begin
            w_direcao = DIR_DIREITA;
        end
    end

    // Target cell and wall check for the selected direction.
    always_comb begin
        w_alvo_x = r_pos_x;
        w_alvo_y = r_pos_y;
        w_fora   = 1'b0;
        case (w_direcao)
            DIR_CIMA: begin
                if (r_pos_y == 3'd7) begin
                    w_fora = 1'b1;
                end else begin
                    w_alvo_y = r_pos_y + 3'd1;
                end
            end
            DIR_BAIXO: begin
                if (r_pos_y == 3'd0) begin
                    w_fora = 1'b1;
                end else begin
                    w_alvo_y = r_pos_y - 3'd1;
                end
            end
            DIR_ESQUERDA: begin
`ifdef RASTREADOR_WRAP_X_EN
                w_alvo_x = r_pos_x - 3'd1;
`else
                if (r_pos_x == 3'd0) begin
                    w_fora = 1'b1;
                end else begin
                    w_alvo_x = r_pos_x - 3'd1;
                end
`endif
            end
            DIR_DIREITA: begin
`ifdef RASTREADOR_WRAP_X_EN
                w_alvo_x = r_pos_x + 3'd1;
`else
                if (r_pos_x == 3'd7) begin
                    w_fora = 1'b1;
                end else begin
                    w_alvo_x = r_pos_x + 3'd1;
                end
`endif
            end
            default: begin
                w_fora = 1'b0;
            end
        endcase
    end

    // Map index is y*8+x; the start cell never counts as an obstacle.
    assign w_indice    = {w_alvo_y, w_alvo_x};
    assign w_obstaculo = MAPA[w_indice] && (w_indice != INDICE_INICIAL);

    // FSM state register; restart always returns to LIVRE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= LIVRE;
        end else if (zeraPosicoes) begin
            r_estado <= LIVRE;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    // FSM next state: commit one move from LIVRE, unlock from BLOQUEIO on the collision strobe.
    always_comb begin
        w_prox_estado = r_estado;
        w_commit      = 1'b0;
        case (r_estado)
            LIVRE: begin
                if (w_tem_evento && desloca) begin
                    w_commit      = 1'b1;
                    w_prox_estado = BLOQUEIO;
                end else begin
                    w_prox_estado = LIVRE;
                end
            end
            BLOQUEIO: begin
                if (checa_colisao) begin
                    w_prox_estado = LIVRE;
                end else begin
                    w_prox_estado = BLOQUEIO;
                end
            end
            default: begin
                w_prox_estado = LIVRE;
            end
        endcase
    end

    // Position, flags and move pulse; restart wins over a same-cycle commit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pos_x    <= X_INICIAL;
            r_pos_y    <= Y_INICIAL;
            r_colisao  <= 1'b0;
            r_fim_mapa <= 1'b0;
            r_borda    <= 1'b0;
        end else if (zeraPosicoes) begin
            r_pos_x    <= X_INICIAL;
            r_pos_y    <= Y_INICIAL;
            r_colisao  <= 1'b0;
            r_fim_mapa <= 1'b0;
            r_borda    <= 1'b0;
        end else if (w_commit) begin
            r_borda <= 1'b1;
            if (w_fora) begin
                r_colisao  <= 1'b1;
                r_fim_mapa <= 1'b0;
            end else begin
                r_pos_x    <= w_alvo_x;
                r_pos_y    <= w_alvo_y;
                r_colisao  <= w_obstaculo;
                r_fim_mapa <= !w_obstaculo && (w_alvo_y == 3'd7);
            end
        end else begin
            r_borda <= 1'b0;
        end
    end

    assign borda_movimento = r_borda;
    assign colisao         = r_colisao;
    assign fim_mapa        = r_fim_mapa;
    assign pos_x           = r_pos_x;
    assign pos_y           = r_pos_y;
    assign db_estado       = r_estado;

endmodule

// File: tb/tb_rastreador_posicao.sv
// Directed bench for rastreador_posicao with DEBOUNCE_CICLOS=4 and the default map.
// Expected values are hand-computed; the wrap case follows RASTREADOR_WRAP_X_EN.
module tb_rastreador_posicao;

    logic       clock;
    logic       reset;
    logic       zeraPosicoes;
    logic       desloca;
    logic       checa_colisao;
    logic [3:0] botoes;
    logic       borda_movimento;
    logic       colisao;
    logic       fim_mapa;
    logic [2:0] pos_x;
    logic [2:0] pos_y;
    logic [1:0] db_estado;

    int n_checks = 0;
    int n_erros  = 0;
    int ciclos;

    rastreador_posicao #(
        .DEBOUNCE_CICLOS (4),
        .MAPA            (64'h0000_0000_0010_0000)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .zeraPosicoes    (zeraPosicoes),
        .desloca         (desloca),
        .checa_colisao   (checa_colisao),
        .botoes          (botoes),
        .borda_movimento (borda_movimento),
        .colisao         (colisao),
        .fim_mapa        (fim_mapa),
        .pos_x           (pos_x),
        .pos_y           (pos_y),
        .db_estado       (db_estado)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verifica(input string tag, input int obs, input int esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s obtido=%0d esperado=%0d", tag, obs, esp);
        end
    endtask

    task automatic passo();
        @(posedge clock);
        #1;
    endtask

    // Edges counted from 0 at the first edge after the call; -1 if no pulse.
    task automatic aguarda_borda(input int limite, output int n);
        n = -1;
        for (int i = 0; i < limite; i++) begin
            @(posedge clock);
            #1;
            if (borda_movimento) begin
                n = i;
                break;
            end
        end
    endtask

    // Press, wait for the commit, check single-cycle pulse, release and settle.
    task automatic pressiona(input logic [3:0] b, output int n);
        botoes = b;
        aguarda_borda(12, n);
        botoes = 4'b0000;
        if (n >= 0) begin
            passo();
            verifica("pulso_unico", borda_movimento, 0);
        end
        repeat (10) passo();
    endtask

    task automatic strobe_checa();
        checa_colisao = 1'b1;
        passo();
        checa_colisao = 1'b0;
    endtask

    task automatic zera();
        zeraPosicoes = 1'b1;
        passo();
        zeraPosicoes = 1'b0;
    endtask

    task automatic verifica_pos(input string tag, input int x, input int y);
        verifica({tag, "_x"}, pos_x, x);
        verifica({tag, "_y"}, pos_y, y);
    endtask

    initial begin
        reset         = 1'b1;
        zeraPosicoes  = 1'b0;
        desloca       = 1'b0;
        checa_colisao = 1'b0;
        botoes        = 4'b0000;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        verifica_pos("reset", 3, 0);
        verifica("reset_borda", borda_movimento, 0);
        verifica("reset_colisao", colisao, 0);
        verifica("reset_fim", fim_mapa, 0);
        verifica("reset_estado", db_estado, 0);

        // Held cima: pulse at edge 6 after first sample
        desloca = 1'b1;
        pressiona(4'b1000, ciclos);
        verifica("latencia_cima", ciclos, 6);
        verifica_pos("cima1", 3, 1);
        verifica("cima1_colisao", colisao, 0);
        verifica("cima1_estado", db_estado, 1);
        strobe_checa();
        verifica("unlock_estado", db_estado, 0);

        // 3-cycle glitch is filtered
        botoes = 4'b1000;
        repeat (3) passo();
        botoes = 4'b0000;
        aguarda_borda(15, ciclos);
        verifica("glitch_sem_borda", ciclos, -1);
        verifica_pos("glitch", 3, 1);

        // Event with desloca=0 is discarded, not queued
        desloca = 1'b0;
        botoes  = 4'b1000;
        aguarda_borda(12, ciclos);
        verifica("desloca0_sem_borda", ciclos, -1);
        desloca = 1'b1;
        aguarda_borda(10, ciclos);
        verifica("desloca0_nao_fila", ciclos, -1);
        botoes = 4'b0000;
        repeat (10) passo();
        verifica_pos("desloca0", 3, 1);

        // cima then direita onto obstacle at (4,2)
        pressiona(4'b1000, ciclos);
        verifica("cima2_lat", ciclos, 6);
        verifica_pos("cima2", 3, 2);
        strobe_checa();
        pressiona(4'b0001, ciclos);
        verifica("direita_lat", ciclos, 6);
        verifica_pos("obstaculo", 4, 2);
        verifica("obstaculo_colisao", colisao, 1);
        verifica("obstaculo_fim", fim_mapa, 0);
        strobe_checa();

        // Restart, walk to x=0, then esquerda at the left edge
        zera();
        verifica_pos("zera1", 3, 0);
        verifica("zera1_colisao", colisao, 0);
        for (int i = 0; i < 3; i++) begin
            pressiona(4'b0010, ciclos);
            strobe_checa();
        end
        verifica_pos("esq_x0", 0, 0);
        verifica("esq_x0_colisao", colisao, 0);
        pressiona(4'b0010, ciclos);
        verifica("borda_esq_lat", ciclos, 6);
`ifdef RASTREADOR_WRAP_X_EN
        verifica_pos("wrap", 7, 0);
        verifica("wrap_colisao", colisao, 0);
`else
        verifica_pos("parede", 0, 0);
        verifica("parede_colisao", colisao, 1);
`endif
        strobe_checa();

        // Seven cima moves to row 7
        zera();
        for (int i = 0; i < 7; i++) begin
            pressiona(4'b1000, ciclos);
            verifica("subida_lat", ciclos, 6);
            if (i < 6) begin
                verifica("subida_fim", fim_mapa, 0);
                strobe_checa();
            end
        end
        verifica_pos("topo", 3, 7);
        verifica("topo_fim", fim_mapa, 1);
        verifica("topo_colisao", colisao, 0);

        // Extra press while locked is ignored
        pressiona(4'b0001, ciclos);
        verifica("bloqueio_ignora", ciclos, -1);
        verifica_pos("bloqueio", 3, 7);
        verifica("bloqueio_fim", fim_mapa, 1);
        verifica("bloqueio_estado", db_estado, 1);

        // zeraPosicoes during BLOQUEIO
        zera();
        verifica_pos("zera2", 3, 0);
        verifica("zera2_fim", fim_mapa, 0);
        verifica("zera2_colisao", colisao, 0);
        verifica("zera2_estado", db_estado, 0);

        // Simultaneous cima + direita: only cima applied
        pressiona(4'b1001, ciclos);
        verifica("simult_lat", ciclos, 6);
        verifica_pos("simult", 3, 1);
        verifica("simult_colisao", colisao, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_erros);
        $finish;
    end

endmodule
